// File: rtl/msm_run_ctrl.sv
// msm_run_ctrl: sequences back-to-back MSM kernel runs and checks results.
// Optional watchdog in START/WAIT: define MSM_RUN_CTRL_TIMEOUT_EN.
module msm_run_ctrl #(
    parameter int EC_BASE_FIELD_WIDTH = 377,
    parameter int ADDR_WIDTH          = 4,
    parameter int BI_ADDR_WIDTH       = 5,
    parameter int NUM_BUCKETS         = 32,
    parameter int RESULT_ADDR         = 0,
    parameter int TIMEOUT_CYCLES      = 1000000,
    parameter int CNT_WIDTH           = 32
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst_n,
    input  logic                           cmd_start,
    input  logic [7:0]                     cmd_runs,
    output logic                           busy,
    output logic                           done,
    output logic [7:0]                     pass_cnt,
    output logic [7:0]                     fail_cnt,
    output logic                           timeout,
    output logic [CNT_WIDTH-1:0]           last_cycles,
    output logic                           k_ap_start,
    input  logic                           k_ap_ready,
    input  logic                           k_ap_done,
    output logic                           bi_owner,
    output logic [BI_ADDR_WIDTH-1:0]       bi_address0,
    output logic                           bi_ce0,
    output logic                           bi_we0,
    output logic [31:0]                    bi_d0,
    output logic [ADDR_WIDTH-1:0]          res_address,
    output logic                           res_ce,
    input  logic [EC_BASE_FIELD_WIDTH-1:0] res_x_q,
    input  logic [EC_BASE_FIELD_WIDTH-1:0] res_y_q,
    input  logic [EC_BASE_FIELD_WIDTH-1:0] res_z_q,
    input  logic [EC_BASE_FIELD_WIDTH-1:0] exp_x,
    input  logic [EC_BASE_FIELD_WIDTH-1:0] exp_y,
    input  logic [EC_BASE_FIELD_WIDTH-1:0] exp_z
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_START, S_WAIT,
        S_READ, S_CHECK, S_NEXT, S_DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [7:0]               runs_q, runs_d;
    logic [7:0]               idx_q, idx_d;
    logic [7:0]               pass_q, pass_d;
    logic [7:0]               fail_q, fail_d;
    logic                     to_q, to_d;
    logic [BI_ADDR_WIDTH-1:0] clr_q, clr_d;
    logic [CNT_WIDTH-1:0]     cyc_q, cyc_d;
    logic [CNT_WIDTH-1:0]     last_q, last_d;

    logic clr_last, in_run, leave_run, to_fire, res_ok, wd_hit;

    assign clr_last  = (clr_q == BI_ADDR_WIDTH'(NUM_BUCKETS - 1));
    assign in_run    = (state_q == S_START) || (state_q == S_WAIT);
    assign leave_run = in_run && (state_d != state_q);
    assign to_fire   = in_run && (state_d == S_DONE);
    assign res_ok    = (res_x_q == exp_x) && (res_y_q == exp_y) &&
                       (res_z_q == exp_z);

`ifdef MSM_RUN_CTRL_TIMEOUT_EN
    assign wd_hit = (cyc_q == CNT_WIDTH'(TIMEOUT_CYCLES));
`else
    logic unused_wd;
    assign unused_wd = ^CNT_WIDTH'(TIMEOUT_CYCLES);
    assign wd_hit    = 1'b0;
`endif

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic; a finished handshake beats the watchdog
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_start)
                    state_d = (cmd_runs == 8'd0) ? S_DONE : S_CLEAR;
            end
            S_CLEAR: if (clr_last) state_d = S_START;
            S_START: begin
                if (k_ap_ready && k_ap_done) state_d = S_READ;
                else if (wd_hit)             state_d = S_DONE;
                else if (k_ap_ready)         state_d = S_WAIT;
            end
            S_WAIT: begin
                if (k_ap_done)   state_d = S_READ;
                else if (wd_hit) state_d = S_DONE;
            end
            S_READ:  state_d = S_CHECK;
            S_CHECK: state_d = S_NEXT;
            S_NEXT: begin
                state_d = (idx_q + 8'd1 == runs_q) ? S_DONE : S_CLEAR;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        busy        = (state_q != S_IDLE) && (state_q != S_DONE);
        done        = (state_q == S_DONE);
        k_ap_start  = (state_q == S_START);
        bi_owner    = (state_q == S_CLEAR);
        bi_ce0      = (state_q == S_CLEAR);
        bi_we0      = (state_q == S_CLEAR);
        bi_address0 = (state_q == S_CLEAR) ? clr_q : '0;
        bi_d0       = 32'd0;
        res_ce      = (state_q == S_READ);
        res_address = (state_q == S_READ) ? ADDR_WIDTH'(RESULT_ADDR) : '0;
    end

    // Datapath next values: run bookkeeping, sweep address, cycle count
    always_comb begin
        runs_d = runs_q;
        idx_d  = idx_q;
        pass_d = pass_q;
        fail_d = fail_q;
        to_d   = to_q;
        clr_d  = clr_q;
        cyc_d  = cyc_q;
        last_d = last_q;
        if (state_q == S_IDLE && cmd_start) begin
            runs_d = cmd_runs;
            idx_d  = 8'd0;
            pass_d = 8'd0;
            fail_d = 8'd0;
            to_d   = 1'b0;
        end
        if (state_q == S_CLEAR) begin
            clr_d = clr_last ? '0 : clr_q + 1'b1;
        end
        if (state_q == S_CLEAR && clr_last) begin
            cyc_d = CNT_WIDTH'(1);
        end else if (in_run && cyc_q != {CNT_WIDTH{1'b1}}) begin
            cyc_d = cyc_q + 1'b1;
        end
        if (leave_run) last_d = cyc_q;
        if (to_fire) begin
            to_d   = 1'b1;
            fail_d = fail_q + 8'd1;
        end
        if (state_q == S_CHECK) begin
            if (res_ok) pass_d = pass_q + 8'd1;
            else        fail_d = fail_q + 8'd1;
        end
        if (state_q == S_NEXT) idx_d = idx_q + 8'd1;
    end

    // Datapath registers
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            runs_q <= '0;
            idx_q  <= '0;
            pass_q <= '0;
            fail_q <= '0;
            to_q   <= 1'b0;
            clr_q  <= '0;
            cyc_q  <= '0;
            last_q <= '0;
        end else begin
            runs_q <= runs_d;
            idx_q  <= idx_d;
            pass_q <= pass_d;
            fail_q <= fail_d;
            to_q   <= to_d;
            clr_q  <= clr_d;
            cyc_q  <= cyc_d;
            last_q <= last_d;
        end
    end

    assign pass_cnt    = pass_q;
    assign fail_cnt    = fail_q;
    assign timeout     = to_q;
    assign last_cycles = last_q;

endmodule

// File: tb/tb_msm_run_ctrl.sv
// tb_msm_run_ctrl: table, random and corner-case runs against a kernel model.
// Watchdog scenario is exercised when MSM_RUN_CTRL_TIMEOUT_EN is defined.
module tb_msm_run_ctrl;

    localparam int W  = 377;
    localparam int NB = 32;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          cmd_start = 1'b0;
    logic [7:0]    cmd_runs = 8'd0;
    logic          busy, done, timeout;
    logic [7:0]    pass_cnt, fail_cnt;
    logic [31:0]   last_cycles;
    logic          k_ap_start;
    logic          k_ap_ready = 1'b0;
    logic          k_ap_done = 1'b0;
    logic          bi_owner, bi_ce0, bi_we0;
    logic [4:0]    bi_address0;
    logic [31:0]   bi_d0;
    logic [3:0]    res_address;
    logic          res_ce;
    logic [W-1:0]  res_x_q, res_y_q, res_z_q;
    logic [W-1:0]  exp_x, exp_y, exp_z;

    msm_run_ctrl #(.TIMEOUT_CYCLES(50)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .cmd_start(cmd_start), .cmd_runs(cmd_runs),
        .busy(busy), .done(done),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .timeout(timeout), .last_cycles(last_cycles),
        .k_ap_start(k_ap_start), .k_ap_ready(k_ap_ready),
        .k_ap_done(k_ap_done), .bi_owner(bi_owner),
        .bi_address0(bi_address0), .bi_ce0(bi_ce0),
        .bi_we0(bi_we0), .bi_d0(bi_d0),
        .res_address(res_address), .res_ce(res_ce),
        .res_x_q(res_x_q), .res_y_q(res_y_q), .res_z_q(res_z_q),
        .exp_x(exp_x), .exp_y(exp_y), .exp_z(exp_z)
    );

    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    always @(posedge ap_clk) cyc++;

    // Kernel behaviour: ready at rdly, done at ddly cycles after start.
    int rdly = 0;
    int ddly = 0;
    int rel  = 0;
    bit kact = 1'b0;
    always @(negedge ap_clk) begin
        if (kact) begin
            rel++;
            if (rel > ddly || !busy) kact = 1'b0;
        end
        if (!kact && k_ap_start) begin
            kact = 1'b1;
            rel  = 0;
        end
        k_ap_ready = kact && (rel == rdly);
        k_ap_done  = kact && (rel == ddly);
    end

    // Per-run corruption code: 0 ok, 1 x msb, 2 y bit0, 3 z bit200
    int bad [0:15];
    int rn = 0, nwr = 0, wr_err = 0, own_err = 0, ndone = 0, done_cyc = 0;
    logic [W-1:0] one_w;
    assign one_w = {{(W-1){1'b0}}, 1'b1};

    // Bus monitor and P_arr read-data model
    always @(negedge ap_clk) begin
        if (cmd_start && !busy) begin
            rn = 0; nwr = 0; wr_err = 0; own_err = 0; ndone = 0;
        end
        if (bi_ce0 && bi_we0) begin
            if (!bi_owner || bi_d0 != 32'd0 || int'(bi_address0) != nwr % NB)
                wr_err++;
            nwr++;
        end
        if (k_ap_start && bi_owner) own_err++;
        if (res_ce) begin
            if (res_address != 4'd0) wr_err++;
            res_x_q = exp_x ^ ((bad[rn] == 1) ? (one_w << (W-1)) : '0);
            res_y_q = exp_y ^ ((bad[rn] == 2) ? one_w : '0);
            res_z_q = exp_z ^ ((bad[rn] == 3) ? (one_w << 200) : '0);
            rn++;
        end
        if (done) begin
            ndone++;
            done_cyc = cyc;
            if (busy) own_err++;
        end
    end

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string name, input longint act,
                       input longint expv);
        nvec++;
        if (act != expv) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic int n_ok(input int runs);
        int n = 0;
        for (int r = 0; r < runs; r++) if (bad[r] == 0) n++;
        return n;
    endfunction

    task automatic run_test(input int runs, input int rd, input int dd,
                            input int inj, input int e_pass,
                            input int e_fail, input int e_last);
        int st, lim;
        rdly = rd;
        ddly = dd;
        @(posedge ap_clk); #1;
        chk("busy_pre", busy, 0);
        cmd_runs  = 8'(runs);
        cmd_start = 1'b1;
        st = cyc;
        @(posedge ap_clk); #1;
        cmd_start = 1'b0;
        chk("busy_rise", busy, (runs != 0) ? 1 : 0);
        lim = runs * (dd + 36) + 10;
        for (int c = 0; c < lim; c++) begin
            if (inj > 0 && cyc - st == inj) begin
                cmd_start = 1'b1;
                cmd_runs  = 8'd3;
            end else begin
                cmd_start = 1'b0;
            end
            @(posedge ap_clk); #1;
        end
        cmd_start = 1'b0;
        chk("done_pulses", ndone, 1);
        if (runs == 0) chk("lat0_le2", (done_cyc - st <= 2) ? 1 : 0, 1);
        else chk("latency", done_cyc - st, runs * (dd + 36) + 1);
        chk("pass_cnt", pass_cnt, e_pass);
        chk("fail_cnt", fail_cnt, e_fail);
        if (e_last >= 0) chk("last_cycles", last_cycles, e_last);
        chk("timeout", timeout, 0);
        chk("bi_writes", nwr, NB * runs);
        chk("bus_err", wr_err + own_err, 0);
        chk("reads", rn, runs);
        chk("busy_end", busy, 0);
    endtask

    typedef struct {
        int runs; int rd; int dd;
        int b0; int b1; int b2;
        int e_pass; int e_fail; int e_last;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [383:0] t;
        int runs, rd, dd, st;
        for (int i = 0; i < 12; i++) t[i*32 +: 32] = $urandom;
        exp_x = t[W-1:0];
        for (int i = 0; i < 12; i++) t[i*32 +: 32] = $urandom;
        exp_y = t[W-1:0];
        for (int i = 0; i < 12; i++) t[i*32 +: 32] = $urandom;
        exp_z = t[W-1:0];
        for (int i = 0; i < 16; i++) bad[i] = 0;

        tbl[0] = '{1, 1, 10, 0, 0, 0, 1, 0, 11};
        tbl[1] = '{3, 1, 10, 0, 2, 0, 2, 1, 11};
        tbl[2] = '{1, 0,  0, 0, 0, 0, 1, 0,  1};
        tbl[3] = '{0, 0,  0, 0, 0, 0, 0, 0,  1};
        tbl[4] = '{2, 3,  3, 0, 0, 0, 2, 0,  4};
        tbl[5] = '{2, 0,  5, 1, 3, 0, 0, 2,  6};

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnts", {pass_cnt, fail_cnt}, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_last", last_cycles, 0);
        chk("rst_kstart", k_ap_start, 0);
        chk("rst_bi", {bi_owner, bi_ce0, bi_we0, res_ce}, 0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;

        foreach (tbl[i]) begin
            bad[0] = tbl[i].b0;
            bad[1] = tbl[i].b1;
            bad[2] = tbl[i].b2;
            run_test(tbl[i].runs, tbl[i].rd, tbl[i].dd, 0,
                     tbl[i].e_pass, tbl[i].e_fail, tbl[i].e_last);
        end

        for (int k = 0; k < 8; k++) begin
            runs = $urandom_range(1, 4);
            rd   = $urandom_range(0, 3);
            dd   = rd + $urandom_range(0, 12);
            for (int r = 0; r < 4; r++)
                bad[r] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            run_test(runs, rd, dd, 0, n_ok(runs), runs - n_ok(runs), dd + 1);
        end

        for (int r = 0; r < 4; r++) bad[r] = 0;
        run_test(1, 1, 30, 50, 1, 0, 31);

        rdly = 1;
        ddly = 10;
        @(posedge ap_clk); #1;
        cmd_runs  = 8'd2;
        cmd_start = 1'b1;
        @(posedge ap_clk); #1;
        cmd_start = 1'b0;
        repeat (10) @(posedge ap_clk);
        #1;
        chk("mid_clear_owner", bi_owner, 1);
        #1;
        ap_rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_bi", {bi_owner, bi_ce0, bi_we0}, 0);
        chk("arst_last", last_cycles, 0);
        chk("arst_cnts", {pass_cnt, fail_cnt}, 0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        run_test(1, 2, 7, 0, 1, 0, 8);

`ifdef MSM_RUN_CTRL_TIMEOUT_EN
        rdly = 1;
        ddly = 100000;
        @(posedge ap_clk); #1;
        cmd_runs  = 8'd3;
        cmd_start = 1'b1;
        st = cyc;
        @(posedge ap_clk); #1;
        cmd_start = 1'b0;
        repeat (150) @(posedge ap_clk);
        #1;
        chk("to_done", ndone, 1);
        chk("to_latency", done_cyc - st, 1 + NB + 50);
        chk("to_flag", timeout, 1);
        chk("to_fail", fail_cnt, 1);
        chk("to_pass", pass_cnt, 0);
        chk("to_writes", nwr, NB);
        chk("to_busy", busy, 0);
        run_test(1, 1, 5, 0, 1, 0, 6);
`else
        rdly = 1;
        ddly = 100000;
        @(posedge ap_clk); #1;
        cmd_runs  = 8'd2;
        cmd_start = 1'b1;
        @(posedge ap_clk); #1;
        cmd_start = 1'b0;
        repeat (200) @(posedge ap_clk);
        #1;
        chk("hang_timeout", timeout, 0);
        chk("hang_busy", busy, 1);
        chk("hang_done", ndone, 0);
        chk("hang_kstart", k_ap_start, 0);
        #1;
        ap_rst_n = 1'b0;
        #1;
        chk("hang_rst_busy", busy, 0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        run_test(1, 1, 5, 0, 1, 0, 6);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
